// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the two-port ALU arbiter.
// slave = arbiter side; master = requesters, response consumer and ALU.
interface alu_req_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [3:0]        req0_fun;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [3:0]        req1_fun;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              busy;

    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [3:0]        ALU_FUN;
    logic              ALU_EN;
    logic [OUT_W-1:0]  ALU_OUT;
    logic              OUT_VALID;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  rsp_ready, ALU_OUT, OUT_VALID,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output rsp_ready, ALU_OUT, OUT_VALID,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer for a shared ALU: accept one op, pulse ALU_EN,
// wait for OUT_VALID (with timeout) and return the result tagged with requester ID.
module alu_req_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned TIMEOUT = 4
) (
    input logic               CLK,
    input logic               RST,
    alu_req_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        fun_q, fun_d;
    logic              id_q, id_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;

    logic gnt_id;
    logic ready0, ready1;

    // rr_q names the requester that wins when both are valid.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = rr_q;
        end else begin
            gnt_id = bus.req1_valid;
        end
        ready0 = (state_q == StIdle) && !gnt_id && bus.req0_valid;
        ready1 = (state_q == StIdle) &&  gnt_id && bus.req1_valid;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (ready0 || ready1) begin
                    a_d     = gnt_id ? bus.req1_a   : bus.req0_a;
                    b_d     = gnt_id ? bus.req1_b   : bus.req0_b;
                    fun_d   = gnt_id ? bus.req1_fun : bus.req0_fun;
                    id_d    = gnt_id;
                    rr_d    = ~gnt_id;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.OUT_VALID) begin
                    data_d  = bus.ALU_OUT;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TimeoutCnt) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.ALU_A      = a_q;
    assign bus.ALU_B      = b_q;
    assign bus.ALU_FUN    = fun_q;
    assign bus.ALU_EN     = (state_q == StIssue);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a small behavioural ALU
// whose response delay is programmable (negative delay = never responds).
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   alu_delay = 0;

    alu_req_arbiter_if #(.DATA_W(8), .OUT_W(8)) bus ();

    alu_req_arbiter #(.DATA_W(8), .OUT_W(8), .TIMEOUT(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: result appears alu_delay+1 cycles after ALU_EN.
    logic [7:0] pend_res;
    logic       pending = 1'b0;
    int         dly = 0;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        bus.OUT_VALID = 1'b0;
        bus.ALU_OUT   = 8'h00;
    end

    always @(posedge clk) begin
        bus.OUT_VALID <= 1'b0;
        if (bus.ALU_EN) begin
            if (alu_delay == 0) begin
                bus.OUT_VALID <= 1'b1;
                bus.ALU_OUT   <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
                pending       <= 1'b0;
            end else if (alu_delay > 0) begin
                pend_res <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
                dly      <= alu_delay;
                pending  <= 1'b1;
            end else begin
                pending <= 1'b0;
            end
        end else if (pending) begin
            if (dly == 1) begin
                bus.OUT_VALID <= 1'b1;
                bus.ALU_OUT   <= pend_res;
                pending       <= 1'b0;
            end
            dly <= dly - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
        checks++; if (bus.ALU_EN !== 1'b0) begin errors++; $display("FAIL reset_alu_en got %0b exp 0", bus.ALU_EN); end
        checks++; if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== 20'h0) begin errors++; $display("FAIL reset_alu_ops got %0h exp 0", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN}); end
        checks++; if ({bus.rsp_data, bus.rsp_id, bus.rsp_err} !== 10'h0) begin errors++; $display("FAIL reset_rsp got %0h exp 0", {bus.rsp_data, bus.rsp_id, bus.rsp_err}); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %0b exp 00", {bus.req0_ready, bus.req1_ready}); end
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        bus.req0_a = 8'd10; bus.req0_b = 8'd3; bus.req0_fun = 4'd0; bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", bus.req0_ready); end
        checks++; if (bus.ALU_EN !== 1'b0) begin errors++; $display("FAIL single_en_T got %0b exp 0", bus.ALU_EN); end
        tick();
        bus.req0_valid = 1'b0;
        checks++; if (bus.ALU_EN !== 1'b1) begin errors++; $display("FAIL single_en_T1 got %0b exp 1", bus.ALU_EN); end
        checks++; if ({bus.ALU_A, bus.ALU_B} !== {8'd10, 8'd3}) begin errors++; $display("FAIL single_ops got %0h exp 0a03", {bus.ALU_A, bus.ALU_B}); end
        tick();
        checks++; if (bus.ALU_EN !== 1'b0) begin errors++; $display("FAIL single_en_T2 got %0b exp 0", bus.ALU_EN); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got %0b exp 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0b exp 1", bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.rsp_id, bus.rsp_err} !== {8'd13, 1'b0, 1'b0}) begin errors++; $display("FAIL single_rsp got %0h exp %0h", {bus.rsp_data, bus.rsp_id, bus.rsp_err}, {8'd13, 2'b00}); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%0b rsp_valid=%0b exp 0 0", bus.busy, bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic       exp_id;
        logic [7:0] exp_data;
        test_reset();
        bus.req0_a = 8'd20;  bus.req0_b = 8'd5;  bus.req0_fun = 4'd1;
        bus.req1_a = 8'hF0;  bus.req1_b = 8'h3C; bus.req1_fun = 4'd2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id   = i[0];
            exp_data = exp_id ? 8'h30 : 8'd15;
            checks++; if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin errors++; $display("FAIL b2b_grant%0d got %0b exp %0b", i, {bus.req0_ready, bus.req1_ready}, {~exp_id, exp_id}); end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL b2b_ready_busy%0d got %0b exp 00", i, {bus.req0_ready, bus.req1_ready}); end
            end
            checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, exp_id, exp_data}) begin errors++; $display("FAIL b2b_rsp%0d got %0h exp %0h", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, exp_id, exp_data}); end
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        alu_delay = -1;
        bus.req1_a = 8'd7; bus.req1_b = 8'd1; bus.req1_fun = 4'd0; bus.req1_valid = 1'b1;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %0b exp 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.busy, bus.rsp_valid} !== 2'b10) begin errors++; $display("FAIL to_wait%0d got busy,rsp_valid=%0b exp 10", i, {bus.busy, bus.rsp_valid}); end
            tick();
        end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== {3'b111, 8'h00}) begin errors++; $display("FAIL to_rsp got %0h exp %0h", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data}, {3'b111, 8'h00}); end
        tick();
        alu_delay = 0;
        bus.req0_a = 8'hAA; bus.req0_b = 8'h0F; bus.req0_fun = 4'd3; bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL to_next_ready got %0b exp 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== {3'b100, 8'hA5}) begin errors++; $display("FAIL to_next_rsp got %0h exp %0h", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data}, {3'b100, 8'hA5}); end
        tick();
    endtask

    task automatic test_rsp_stall();
        bus.rsp_ready = 1'b0;
        bus.req0_a = 8'd100; bus.req0_b = 8'd27; bus.req0_fun = 4'd0; bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_a = 8'd9; bus.req1_b = 8'd4; bus.req1_fun = 4'd1; bus.req1_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== {3'b100, 8'd127}) begin errors++; $display("FAIL stall_rsp%0d got %0h exp %0h", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data}, {3'b100, 8'd127}); end
            checks++; if ({bus.req1_ready, bus.ALU_EN} !== 2'b00) begin errors++; $display("FAIL stall_quiet%0d got ready,en=%0b exp 00", i, {bus.req1_ready, bus.ALU_EN}); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++; if ({bus.busy, bus.rsp_valid, bus.req1_ready} !== 3'b001) begin errors++; $display("FAIL stall_release got busy,rsp_valid,ready=%0b exp 001", {bus.busy, bus.rsp_valid, bus.req1_ready}); end
        tick();
        bus.req1_valid = 1'b0;
        checks++; if ({bus.ALU_EN, bus.ALU_A} !== {1'b1, 8'd9}) begin errors++; $display("FAIL stall_next_issue got %0h exp %0h", {bus.ALU_EN, bus.ALU_A}, {1'b1, 8'd9}); end
        tick();
        tick();
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b11, 8'd5}) begin errors++; $display("FAIL stall_next_rsp got %0h exp %0h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {2'b11, 8'd5}); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        alu_delay = 3;
        bus.req0_a = 8'd1; bus.req0_b = 8'd2; bus.req0_fun = 4'd0; bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_delay = 0;
        checks++; if ({bus.busy, bus.rsp_valid, bus.ALU_EN} !== 3'b000) begin errors++; $display("FAIL rstmid_idle got busy,rsp_valid,en=%0b exp 000", {bus.busy, bus.rsp_valid, bus.ALU_EN}); end
        checks++; if (bus.ALU_A !== 8'd0) begin errors++; $display("FAIL rstmid_alu_a got %0h exp 0", bus.ALU_A); end
        // Late OUT_VALID from the aborted op lands in one of these idle cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_late%0d got busy,rsp_valid=%0b exp 00", i, {bus.busy, bus.rsp_valid}); end
        end
        bus.req0_a = 8'd50; bus.req0_b = 8'd8; bus.req0_fun = 4'd1; bus.req0_valid = 1'b1;
        bus.req1_a = 8'd1;  bus.req1_b = 8'd1; bus.req1_fun = 4'd0; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_rr got %0b exp 10", {bus.req0_ready, bus.req1_ready}); end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        tick();
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== {3'b100, 8'd42}) begin errors++; $display("FAIL rstmid_rsp got %0h exp %0h", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data}, {3'b100, 8'd42}); end
        tick();
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fun = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fun = '0;
        bus.rsp_ready  = 1'b1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_timeout();
        test_rsp_stall();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
